// File: rtl/ds_sched_if.sv
// ds_sched_if: bundles the buffer-side handshakes, the modulator issue/return
// path and the PWM write port of the ds_sched round-robin scheduler.
//
// Modports:
//   slave  - the scheduler (ds_sched) side
//   master - the surrounding datapath: ping-pong buffers, modulator, PWM buffers
//
// Signals:
//   l_valid/l_din/l_ready, r_valid/r_din/r_ready  per-channel sample handshake
//   l_space, r_space                              PWM buffer can take a word
//   ds_din, ds_ch, ds_valid                       issue to the modulator
//   ds_ret_valid, ds_ret_ch, ds_ret_dout          modulator output and its tag
//   l_wr, r_wr, wr_dout                           PWM buffer write port
//   underrun_l, underrun_r, underrun_clr          starvation flags (optional)
interface ds_sched_if #(
    parameter int DW = 16
) ();
    logic          l_valid;
    logic [DW-1:0] l_din;
    logic          l_ready;
    logic          r_valid;
    logic [DW-1:0] r_din;
    logic          r_ready;
    logic          l_space;
    logic          r_space;
    logic [DW-1:0] ds_din;
    logic          ds_ch;
    logic          ds_valid;
    logic          ds_ret_valid;
    logic          ds_ret_ch;
    logic [3:0]    ds_ret_dout;
    logic          l_wr;
    logic          r_wr;
    logic [3:0]    wr_dout;
    logic          underrun_l;
    logic          underrun_r;
    logic          underrun_clr;

    modport slave (
        input  l_valid, l_din, r_valid, r_din, l_space, r_space,
        input  ds_ret_valid, ds_ret_ch, ds_ret_dout, underrun_clr,
        output l_ready, r_ready, ds_din, ds_ch, ds_valid,
        output l_wr, r_wr, wr_dout, underrun_l, underrun_r
    );

    modport master (
        output l_valid, l_din, r_valid, r_din, l_space, r_space,
        output ds_ret_valid, ds_ret_ch, ds_ret_dout, underrun_clr,
        input  l_ready, r_ready, ds_din, ds_ch, ds_valid,
        input  l_wr, r_wr, wr_dout, underrun_l, underrun_r
    );
endinterface

// File: rtl/ds_sched.sv
// ds_sched: round-robin scheduler time-sharing one delta-sigma modulator
// between the left and right channels. Admits at most one sample per issue
// slot, spaces issues by GAP idle cycles, tags each issue with its channel and
// steers the tagged modulator output to the matching PWM buffer.
//
// Ports:
//   ACLK  - system clock
//   ARST  - asynchronous active-high reset
//   bus   - ds_sched_if.slave (sample handshakes, issue, return, PWM writes,
//           underrun flags)
//
// Parameters: DW sample width, GAP idle cycles after each issue (1..15),
// UNDERRUN_LIM starved cycles before an underrun flag sets.
//
// Optional feature: define DS_SCHED_UNDERRUN_EN to build the per-channel
// starvation counters and sticky underrun flags. Without it the flags are
// tied low and underrun_clr is ignored.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for an eligible channel; grant happens in this cycle
// ST_GAP  | issue in flight; GAP cycles with both readys low
module ds_sched #(
    parameter int DW           = 16,
    parameter int GAP          = 5,
    parameter int UNDERRUN_LIM = 64
) (
    input logic       ACLK,
    input logic       ARST,
    ds_sched_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_nxt;
    logic       last;
    logic       grant;
    logic       grant_ch;
    logic       l_elig;
    logic       r_elig;

    assign l_elig = bus.l_valid & bus.l_space;
    assign r_elig = bus.r_valid & bus.r_space;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Ready is combinational from the grant, so it is gated with ARST to keep
    // both readys low while reset is held with eligible inputs.
    always_comb begin
        state_nxt     = state;
        gap_cnt_nxt   = gap_cnt;
        grant         = 1'b0;
        grant_ch      = 1'b0;
        bus.l_ready   = 1'b0;
        bus.r_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ARST && (l_elig || r_elig)) begin
                    grant       = 1'b1;
                    // R wins when it is alone, or on a tie when L went last.
                    grant_ch    = r_elig & (~l_elig | ~last);
                    bus.l_ready = ~grant_ch;
                    bus.r_ready = grant_ch;
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = 4'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // last resets to R so the first tie goes to L.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            bus.ds_valid <= 1'b0;
            bus.ds_din   <= '0;
            bus.ds_ch    <= 1'b0;
            last         <= 1'b1;
        end else begin
            bus.ds_valid <= grant;
            if (grant) begin
                bus.ds_din <= grant_ch ? bus.r_din : bus.l_din;
                bus.ds_ch  <= grant_ch;
                last       <= grant_ch;
            end
        end
    end

    // Return demux runs independently of the issue FSM.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            bus.l_wr    <= 1'b0;
            bus.r_wr    <= 1'b0;
            bus.wr_dout <= '0;
        end else begin
            bus.l_wr <= bus.ds_ret_valid & ~bus.ds_ret_ch;
            bus.r_wr <= bus.ds_ret_valid & bus.ds_ret_ch;
            if (bus.ds_ret_valid) begin
                bus.wr_dout <= bus.ds_ret_dout;
            end
        end
    end

`ifdef DS_SCHED_UNDERRUN_EN
    localparam int UW = $clog2(UNDERRUN_LIM + 1);
    localparam logic [UW-1:0] LIM = UW'(UNDERRUN_LIM);

    logic [1:0]    feed;
    logic [1:0]    starve;
    logic [1:0]    ur_flag;
    logic [UW-1:0] ur_cnt [2];

    assign feed   = {bus.r_valid, bus.l_valid};
    assign starve = {bus.r_space & ~bus.r_valid, bus.l_space & ~bus.l_valid};

    // Counter saturates at LIM; the flag sets on the increment that reaches it.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            ur_flag   <= '0;
            ur_cnt[0] <= '0;
            ur_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.underrun_clr) begin
                    ur_cnt[i]  <= '0;
                    ur_flag[i] <= 1'b0;
                end else if (feed[i]) begin
                    ur_cnt[i] <= '0;
                end else if (starve[i] && ur_cnt[i] != LIM) begin
                    ur_cnt[i] <= ur_cnt[i] + 1'b1;
                    if (ur_cnt[i] == LIM - 1'b1) begin
                        ur_flag[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.underrun_l = ur_flag[0];
    assign bus.underrun_r = ur_flag[1];
`else
    localparam int unused_lim = UNDERRUN_LIM;
    logic unused_clr;

    assign unused_clr     = bus.underrun_clr;
    assign bus.underrun_l = 1'b0;
    assign bus.underrun_r = 1'b0;
`endif
endmodule

// File: doc/ds_sched.md
# ds_sched

Round-robin scheduler that time-shares one ΔΣ modulator between the left and right channels. It sits between the two per-channel ping-pong buffers and the modulator. It admits at most one sample per issue slot and paces issues with a programmable gap. It tags each issued sample with its channel and demultiplexes the modulator's 4-bit output back to the correct PWM buffer.

## Interface
- DW, 16, sample width.
- GAP, 5, idle cycles enforced after each issue (legal range 1..15). Matches the modulator's inter-sample wait.
- UNDERRUN_LIM, 64, consecutive starved cycles before the underrun flag sets. Used only with DS_SCHED_UNDERRUN_EN.

Ports (name, direction, width, meaning):
- ACLK  in  1  system clock. Single clock domain.
- ARST  in  1  reset, asynchronous, active-high.
- l_valid  in  1  left sample available.
- l_din  in  DW  left sample, signed.
- l_ready  out  1  left sample accepted this cycle.
- r_valid / r_din / r_ready  same as left, for the right channel.
- l_space  in  1  left PWM buffer can take a word.
- r_space  in  1  right PWM buffer can take a word.
- ds_din  out  DW  sample to the modulator.
- ds_ch  out  1  channel tag of ds_din (0 = L, 1 = R).
- ds_valid  out  1  one-cycle issue strobe.
- ds_ret_valid  in  1  modulator output strobe.
- ds_ret_ch  in  1  tag returned with the modulator output.
- ds_ret_dout  in  4  modulator output word.
- l_wr  out  1  write strobe to the left PWM buffer.
- r_wr  out  1  write strobe to the right PWM buffer.
- wr_dout  out  4  data for l_wr / r_wr.
- underrun_l  out  1  sticky starvation flag, left. Only with the macro.
- underrun_r  out  1  sticky starvation flag, right. Only with the macro.
- underrun_clr  in  1  clears both underrun flags. Only with the macro.

## Operation
- Eligibility: a channel is eligible when its valid and its space are both high.
- State machine states: IDLE, GAP.
- IDLE:
  - If no channel is eligible, stay in IDLE.
  - If exactly one channel is eligible, grant it.
  - If both are eligible, grant the channel not granted last. This uses the `last` pointer, which resets to R so L wins the first tie.
  - On a grant: assert the granted channel's ready combinationally in the same cycle; register din to ds_din and the channel to ds_ch; update `last`; go to GAP.
- GAP:
  - Both ready outputs are low.
  - A counter loads GAP-1 on entry and decrements each cycle.
  - At 0, the next state is IDLE.
- ds_valid is asserted only in the first GAP cycle.
- ds_din and ds_ch hold their values until the next issue.
- Return path: a registered demux.
  - On ds_ret_valid, the next cycle pulses l_wr if ds_ret_ch = 0, otherwise r_wr.
  - wr_dout is registered together with the strobe.
  - The return path is independent of the state machine. Returns and issues may occur in the same cycle without interaction.
- No credit tracking: the space signals are sampled only at grant time. The PWM buffer must have space for every word in flight.

## Timing
- Reset values: l_ready = 0, r_ready = 0, ds_valid = 0, ds_din = 0, ds_ch = 0, l_wr = 0, r_wr = 0, wr_dout = 0, underrun_l = 0, underrun_r = 0, state = IDLE, `last` = R.
- Handshake in cycle t produces ds_valid at t+1. Latency is 1.
- State is GAP from t+1 to t+GAP and IDLE at t+GAP+1.
- Minimum issue spacing is GAP+1 cycles. For GAP = 5 this is 6 cycles, or 12 cycles per L/R pair.
- ds_ret_valid at t produces l_wr / r_wr at t+1.
- A valid that drops in IDLE before the grant is ignored. There is no accept without ready.
- If ARST asserts mid-GAP: everything returns to reset values asynchronously, any issued sample is forgotten, and a pending return strobe is dropped.

## Configuration
- DS_SCHED_UNDERRUN_EN
- Defined:
  - A per-channel counter increments each cycle that space = 1 and valid = 0, and clears when valid = 1.
  - When the counter reaches UNDERRUN_LIM, the channel's underrun flag sets and stays set.
  - The counter saturates at UNDERRUN_LIM.
  - underrun_clr clears both flags and both counters. If clear and a new underrun condition occur in the same cycle, clear wins.
- Undefined: underrun_l and underrun_r are tied to 0, underrun_clr is ignored, and no counters are built.

## Test plan
- Reset: hold ARST 3 cycles -> all outputs 0. Release with both channels eligible -> l_ready in the first IDLE cycle and ds_ch = 0 one cycle later.
- Alternation: both channels valid continuously, samples L = 0x1234 and R = 0x8001, GAP = 5 -> ds_valid every 6 cycles with ds_ch sequence 0,1,0,1 and matching ds_din.
- Backpressure: r_space = 0 with both channels valid -> only L issued, every 6 cycles. Set r_space = 1 -> the next tie is granted to R.
- Return demux: ds_ret_valid with ch = 1 and dout = 0xA -> r_wr = 1 and wr_dout = 0xA the next cycle, l_wr stays 0. A return during a ds_valid cycle is unaffected.
- Mid-operation reset: assert ARST in the 3rd GAP cycle -> immediate IDLE, and the next grant goes to L.
- With DS_SCHED_UNDERRUN_EN defined and UNDERRUN_LIM = 64: l_space = 1 and l_valid = 0 for 64 cycles -> underrun_l sets. Pulse underrun_clr -> the flag clears. Re-enter starvation for 63 cycles -> no flag.
